acumulador_selectivo_param: RTL
===============================

// Module: acumulador_selectivo_param
// PURPOSE
//   Parametrised selective adder + accumulator. Each accepted sample picks an operand from
//   i_data1/i_data2 via i_sel and adds it to, or subtracts it from, a registered accumulator.
//   Out-of-range results either wrap or saturate. Provides a one-cycle overflow pulse, a sticky
//   overflow flag, an output-valid strobe and a sample counter. Sits between the input data
//   path and the result/monitor logic.
// PARAMETERS
//   NB_DATA   3  width of i_data1/i_data2 (unsigned)
//   NB_ACC    6  accumulator/o_data width (unsigned); must satisfy NB_ACC > NB_DATA
//   SATURATE  0  0: wrap modulo 2^NB_ACC; 1: clamp to 2^NB_ACC-1 (add) or 0 (sub)
//   NB_CNT    8  width of accepted-sample counter o_count
// PORTS
//   clk          in   1         clock, all state on rising edge
//   i_rst        in   1         synchronous reset, active-high
//   i_data1      in   NB_DATA   operand A
//   i_data2      in   NB_DATA   operand B
//   i_sel        in   2         operand select: 00 B, 01 A+B, 10 A, 11 zero
//   i_sub        in   1         0: acc += operand; 1: acc -= operand
//   i_valid      in   1         sample accept strobe
//   i_clear      in   1         synchronous clear of acc, count, sticky flag
//   o_data       out  NB_ACC    accumulator value
//   o_overflow   out  1         one-cycle pulse: last accepted sample overflowed/underflowed
//   o_ovf_sticky out  1         set on any overflow/underflow, held until i_rst/i_clear
//   o_valid      out  1         high one cycle after each accepted sample
//   o_count      out  NB_CNT    number of accepted samples, wraps at 2^NB_CNT
// BEHAVIOUR
//   - Operand is combinational, NB_DATA+1 bits; A+B never truncates (max 2*(2^NB_DATA-1)).
//   - Result is computed at NB_ACC+1 bits: add -> acc+op, carry = bit NB_ACC;
//     sub -> acc-op, borrow = bit NB_ACC.
//   - Cycle priority: i_rst > i_clear > i_valid > hold.
//   - i_rst=1: o_data=0, o_overflow=0, o_ovf_sticky=0, o_valid=0, o_count=0 on next edge.
//     Applies mid-accumulation; no partial state survives.
//   - i_clear=1 (no reset): o_data, o_count, o_ovf_sticky <= 0; o_overflow <= 0; o_valid <= 0.
//     A concurrent i_valid sample is dropped (not counted).
//   - i_valid=1 (no rst/clear): on the edge o_data <= result, o_valid <= 1,
//     o_count <= o_count+1, o_overflow <= carry|borrow, sticky |= carry|borrow.
//     Latency 1 clk from input to o_data/o_valid/o_overflow.
//   - Wrap (SATURATE=0): o_data = result[NB_ACC-1:0].
//   - Saturate (SATURATE=1): on carry o_data = 2^NB_ACC-1; on borrow o_data = 0;
//     overflow flags still assert.
//   - i_valid=0: o_data, o_count, sticky hold; o_valid=0, o_overflow=0.
//   - i_sel=11 with i_valid=1: counted sample, acc unchanged, no overflow.
//   - Back-to-back i_valid is supported every cycle; no backpressure.
// TESTING (defaults NB_DATA=3, NB_ACC=6 unless stated)
//   1. i_rst=1 for 3 clk, then random inputs with i_valid=0 -> all outputs stay 0.
//   2. A=2, B=1, i_valid one cycle each for i_sel=00,01,10,11 (add) -> o_data 1,4,6,6;
//      o_count=4; o_valid pulses every cycle.
//   3. SATURATE=0: A=B=1, i_sel=01, i_valid held 32 clk -> o_data 2..62 then 0 on 32nd;
//      o_overflow pulses once on that cycle; o_ovf_sticky stays 1.
//   4. SATURATE=1: same stimulus -> o_data clamps at 63 on 32nd sample, stays 63 after;
//      i_sub=1, A=7, sel=10, 10 samples -> o_data reaches 0 and holds; overflow pulses on
//      underflow.
//   5. i_clear and i_valid asserted together while o_data=30, sticky=1 -> next cycle
//      o_data=0, o_count=0, sticky=0, o_valid=0.
//   6. i_rst asserted mid-run (o_data=40, o_count=20) with i_valid=1 -> next edge all outputs 0;
//      accumulation restarts from 0 after release.

Source files
------------

// File: rtl/acumulador_selectivo_param.sv
// Selective adder/subtractor feeding a registered accumulator with wrap or saturate on
// out-of-range results, plus overflow pulse, sticky flag, valid strobe and sample counter.
module acumulador_selectivo_param #(
   parameter int NB_DATA  = 3,
   parameter int NB_ACC   = 6,
   parameter int SATURATE = 0,
   parameter int NB_CNT   = 8
) (
   input  logic              clk,
   input  logic              i_rst,
   input  logic [NB_DATA-1:0] i_data1,
   input  logic [NB_DATA-1:0] i_data2,
   input  logic [1:0]        i_sel,
   input  logic              i_sub,
   input  logic              i_valid,
   input  logic              i_clear,
   output logic [NB_ACC-1:0] o_data,
   output logic              o_overflow,
   output logic              o_ovf_sticky,
   output logic              o_valid,
   output logic [NB_CNT-1:0] o_count
);

   localparam bit                SAT_EN  = (SATURATE != 0);
   localparam logic [NB_CNT-1:0] CNT_ONE = {{(NB_CNT-1){1'b0}}, 1'b1};

   logic [NB_DATA:0]    operand_s;
   logic [NB_ACC:0]     operand_ext_s;
   logic [NB_ACC:0]     result_s;
   logic                flow_s;
   logic [NB_ACC-1:0]   next_data_s;

   logic [NB_ACC-1:0]   data_r;
   logic                overflow_r;
   logic                sticky_r;
   logic                valid_r;
   logic [NB_CNT-1:0]   count_r;

   // Operand selection; A+B is formed one bit wider so it never truncates.
   always_comb begin
      operand_s = {(NB_DATA+1){1'b0}};
      case (i_sel)
         2'b00:   operand_s = {1'b0, i_data2};
         2'b01:   operand_s = {1'b0, i_data1} + {1'b0, i_data2};
         2'b10:   operand_s = {1'b0, i_data1};
         2'b11:   operand_s = {(NB_DATA+1){1'b0}};
         default: operand_s = {(NB_DATA+1){1'b0}};
      endcase
   end

   // Extra top bit of the result is the carry on add and the borrow on subtract.
   always_comb begin
      operand_ext_s = {{(NB_ACC-NB_DATA){1'b0}}, operand_s};
      result_s      = {(NB_ACC+1){1'b0}};
      if (i_sub) begin
         result_s = {1'b0, data_r} - operand_ext_s;
      end else begin
         result_s = {1'b0, data_r} + operand_ext_s;
      end
      flow_s = result_s[NB_ACC];
   end

   // Out-of-range handling: clamp toward the violated bound or keep the wrapped bits.
   always_comb begin
      next_data_s = result_s[NB_ACC-1:0];
      if (SAT_EN && flow_s) begin
         if (i_sub) begin
            next_data_s = {NB_ACC{1'b0}};
         end else begin
            next_data_s = {NB_ACC{1'b1}};
         end
      end else begin
         next_data_s = result_s[NB_ACC-1:0];
      end
   end

   // State update with priority reset > clear > accepted sample > hold.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         data_r     <= {NB_ACC{1'b0}};
         overflow_r <= 1'b0;
         sticky_r   <= 1'b0;
         valid_r    <= 1'b0;
         count_r    <= {NB_CNT{1'b0}};
      end else if (i_clear) begin
         data_r     <= {NB_ACC{1'b0}};
         overflow_r <= 1'b0;
         sticky_r   <= 1'b0;
         valid_r    <= 1'b0;
         count_r    <= {NB_CNT{1'b0}};
      end else if (i_valid) begin
         data_r     <= next_data_s;
         overflow_r <= flow_s;
         sticky_r   <= sticky_r | flow_s;
         valid_r    <= 1'b1;
         count_r    <= count_r + CNT_ONE;
      end else begin
         overflow_r <= 1'b0;
         valid_r    <= 1'b0;
      end
   end

   assign o_data       = data_r;
   assign o_overflow   = overflow_r;
   assign o_ovf_sticky = sticky_r;
   assign o_valid      = valid_r;
   assign o_count      = count_r;

endmodule
